dtw_seq_ctrl: RTL and testbench
===============================

DTW_SEQ_CTRL -- requirements
Module: dtw_seq_ctrl

Interface
REQ-001 Parameters SHALL be: N, default 32, sample width; AW, default 8, address width; Sample, default 256, memory depth (=2^AW).
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset
- wr_en  in  1  load-port write strobe
- wr_sel  in  1  0 = template memory, 1 = test memory
- wr_data  in  N  sample to write
- wr_clr  in  1  clear both write pointers and counts
- start  in  1  begin traversal
- abort  in  1  cancel traversal
- temp_mem_addr, test_mem_addr  out  AW  memory addresses
- temp_mem_write_enable, test_mem_write_enable  out  1  memory write enables
- template_data, test_data  out  N  memory write data
- temp_memory_out, test_memory_out  in  N  memory read data, 1-cycle latency
- pair_valid  out  1  sample pair valid
- pair_ready  in  1  consumer accepts pair
- pair_temp, pair_test  out  N  sample pair (direct from memory read data)
- pair_i, pair_j  out  AW  test index i, template index j
- first_col, last_col, last_pair  out  1  j==0, j==temp_cnt-1, final pair
- temp_cnt, test_cnt  out  AW+1  stored sample counts, 0..Sample
- busy, done, start_err  out  1  status; done and start_err are 1-cycle pulses

Function
REQ-003 States SHALL be IDLE, PRIME, RUN, DONE.
REQ-004 IDLE load: wr_en=1 SHALL assert the selected memory's write enable in the same cycle (combinational), with address = that memory's write pointer and data = wr_data; on the following edge the pointer and count SHALL increment.
REQ-005 A write when the selected count == Sample SHALL be dropped: no write enable, count holds.
REQ-006 wr_clr SHALL zero both pointers and counts on the next edge; if wr_clr and wr_en are both high, wr_clr wins and no write occurs.
REQ-007 wr_en and wr_clr SHALL be ignored outside IDLE.
REQ-008 start in IDLE with both counts nonzero SHALL:
- go to PRIME;
- drive both read addresses to 0 and both write enables low.
REQ-009 start in IDLE with either count zero SHALL pulse start_err for 1 cycle and remain in IDLE.
REQ-010 start together with wr_en SHALL take the start and drop the write.
REQ-011 PRIME SHALL last exactly 1 cycle (BRAM latency) and then go to RUN.
REQ-012 In RUN, pair_valid SHALL be 1, with:
- pair_temp = temp_memory_out and pair_test = test_memory_out;
- pair_i and pair_j the indices of the address issued in the previous cycle.
REQ-013 Traversal SHALL be row-major: i from 0 to test_cnt-1 (outer), j from 0 to temp_cnt-1 (inner), totalling temp_cnt*test_cnt pairs.
REQ-014 Read addresses SHALL advance to the next (i,j) only on a cycle with pair_valid && pair_ready.
- While pair_ready=0, addresses, indices and pair outputs SHALL hold stable.
REQ-015 j wraps to 0 and i increments when j == temp_cnt-1; last_pair = (i==test_cnt-1 && j==temp_cnt-1).
REQ-016 Acceptance of last_pair SHALL move to DONE; DONE SHALL pulse done for 1 cycle, then return to IDLE.
REQ-017 Stored counts SHALL be preserved across a traversal, so a re-start is possible without reload.
REQ-018 busy SHALL be 1 in PRIME, RUN and DONE.
REQ-019 abort in PRIME or RUN SHALL go to IDLE on the next edge with no done pulse; abort has priority over pair acceptance.
REQ-020 Count Sample (256) SHALL be legal, with indices reaching 255 without overflow.

Reset
REQ-021 rst=0 SHALL asynchronously force:
- state IDLE;
- pointers, counts, indices, pair_i and pair_j to 0;
- all write enables, pair_valid, busy, done and start_err to 0;
- both addresses to 0.
REQ-022 Reset mid-traversal SHALL abandon it and clear stored counts; memory contents are not cleared.
REQ-023 The first cycle after rst deasserts SHALL accept wr_en or start normally.

Verification
REQ-024 Load 3 template and 2 test samples, start, pair_ready=1 -> PRIME 1 cycle, then 6 consecutive pairs (i,j) = (0,0),(0,1),(0,2),(1,0),(1,1),(1,2) with matching data; last_pair on (1,2); done 1 cycle later; busy=0 after.
REQ-025 Same load, pair_ready toggled 1,0,0,1 -> each pair held stable while pair_ready=0; no pair duplicated or skipped; 6 pairs total.
REQ-026 Write 257 template samples -> temp_cnt=256; 257th write has no write enable; start with test_cnt=0 -> start_err pulse, busy stays 0.
REQ-027 wr_clr together with wr_en, then start -> no write, counts 0, start_err pulse.
REQ-028 abort at the 3rd pair -> IDLE next cycle, no done; re-start gives the full 6-pair sequence again from (0,0).
REQ-029 rst low during RUN -> all outputs at reset values immediately; counts 0 after release.

Source files
------------

// File: rtl/dtw_seq_ctrl.sv
// rtl/dtw_seq_ctrl.sv - DTW sample-pair sequencer: loads template/test memories and streams (i,j) pairs row-major.
module dtw_seq_ctrl #(
  parameter int N      = 32,
  parameter int AW     = 8,
  parameter int Sample = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic          wr_sel,
  input  logic [N-1:0]  wr_data,
  input  logic          wr_clr,
  input  logic          start,
  input  logic          abort,
  output logic [AW-1:0] temp_mem_addr,
  output logic [AW-1:0] test_mem_addr,
  output logic          temp_mem_write_enable,
  output logic          test_mem_write_enable,
  output logic [N-1:0]  template_data,
  output logic [N-1:0]  test_data,
  input  logic [N-1:0]  temp_memory_out,
  input  logic [N-1:0]  test_memory_out,
  output logic          pair_valid,
  input  logic          pair_ready,
  output logic [N-1:0]  pair_temp,
  output logic [N-1:0]  pair_test,
  output logic [AW-1:0] pair_i,
  output logic [AW-1:0] pair_j,
  output logic          first_col,
  output logic          last_col,
  output logic          last_pair,
  output logic [AW:0]   temp_cnt,
  output logic [AW:0]   test_cnt,
  output logic          busy,
  output logic          done,
  output logic          start_err
);

  typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} state_t;

  localparam logic [AW:0] FULL = (AW+1)'(Sample);

  state_t        state_q, state_d;
  logic [AW-1:0] temp_ptr_q, temp_ptr_d, test_ptr_q, test_ptr_d;
  logic [AW:0]   temp_cnt_q, temp_cnt_d, test_cnt_q, test_cnt_d;
  logic [AW-1:0] pi_q, pi_d, pj_q, pj_d;
  logic          start_err_q, start_err_d;

  logic          idle, start_ok, start_bad, clr_go, wr_go, temp_wr, test_wr;
  logic          accept, last_i, last_j, is_last;
  logic [AW-1:0] rd_i, rd_j;

  assign idle      = (state_q == IDLE);
  assign start_ok  = idle && start && (temp_cnt_q != '0) && (test_cnt_q != '0);
  assign start_bad = idle && start && !start_ok;
  assign clr_go    = idle && wr_clr && !start_ok;
  // Start and clear both pre-empt a load write in the same cycle.
  assign wr_go     = idle && wr_en && !wr_clr && !start;
  assign temp_wr   = wr_go && !wr_sel && (temp_cnt_q != FULL);
  assign test_wr   = wr_go &&  wr_sel && (test_cnt_q != FULL);

  assign accept  = (state_q == RUN) && pair_ready && !abort;
  assign last_j  = ({1'b0, pj_q} == (temp_cnt_q - 1'b1));
  assign last_i  = ({1'b0, pi_q} == (test_cnt_q - 1'b1));
  assign is_last = last_i && last_j;

  // Address issued this cycle; memory data for it is presented next cycle.
  always_comb begin
    rd_i = pi_q;
    rd_j = pj_q;
    if (state_q == PRIME) begin
      rd_i = '0;
      rd_j = '0;
    end else if (accept && !is_last) begin
      if (last_j) begin
        rd_i = pi_q + 1'b1;
        rd_j = '0;
      end else begin
        rd_j = pj_q + 1'b1;
      end
    end
  end

  always_comb begin
    temp_ptr_d  = temp_ptr_q;
    test_ptr_d  = test_ptr_q;
    temp_cnt_d  = temp_cnt_q;
    test_cnt_d  = test_cnt_q;
    pi_d        = pi_q;
    pj_d        = pj_q;
    start_err_d = start_bad;
    if (clr_go) begin
      temp_ptr_d = '0;
      test_ptr_d = '0;
      temp_cnt_d = '0;
      test_cnt_d = '0;
    end else begin
      if (temp_wr) begin
        temp_ptr_d = temp_ptr_q + 1'b1;
        temp_cnt_d = temp_cnt_q + 1'b1;
      end
      if (test_wr) begin
        test_ptr_d = test_ptr_q + 1'b1;
        test_cnt_d = test_cnt_q + 1'b1;
      end
    end
    if (start_ok) begin
      pi_d = '0;
      pj_d = '0;
    end else if (state_q == PRIME || state_q == RUN) begin
      pi_d = rd_i;
      pj_d = rd_j;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      temp_ptr_q  <= '0;
      test_ptr_q  <= '0;
      temp_cnt_q  <= '0;
      test_cnt_q  <= '0;
      pi_q        <= '0;
      pj_q        <= '0;
      start_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      temp_ptr_q  <= temp_ptr_d;
      test_ptr_q  <= test_ptr_d;
      temp_cnt_q  <= temp_cnt_d;
      test_cnt_q  <= test_cnt_d;
      pi_q        <= pi_d;
      pj_q        <= pj_d;
      start_err_q <= start_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = PRIME;
      PRIME:   state_d = abort ? IDLE : RUN;
      RUN: begin
        if (abort)                  state_d = IDLE;
        else if (accept && is_last) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy                  = (state_q != IDLE);
    pair_valid            = (state_q == RUN);
    done                  = (state_q == DONE);
    temp_mem_write_enable = temp_wr && rst;
    test_mem_write_enable = test_wr && rst;
    temp_mem_addr         = '0;
    test_mem_addr         = '0;
    case (state_q)
      IDLE: begin
        if (!start_ok) begin
          temp_mem_addr = temp_ptr_q;
          test_mem_addr = test_ptr_q;
        end
      end
      PRIME, RUN: begin
        temp_mem_addr = rd_j;
        test_mem_addr = rd_i;
      end
      default: ;
    endcase
  end

  assign template_data = wr_data;
  assign test_data     = wr_data;
  assign pair_temp     = temp_memory_out;
  assign pair_test     = test_memory_out;
  assign pair_i        = pi_q;
  assign pair_j        = pj_q;
  assign first_col     = pair_valid && (pj_q == '0);
  assign last_col      = pair_valid && last_j;
  assign last_pair     = pair_valid && is_last;
  assign temp_cnt      = temp_cnt_q;
  assign test_cnt      = test_cnt_q;
  assign start_err     = start_err_q;

endmodule

// File: tb/tb_dtw_seq_ctrl.sv
// tb/tb_dtw_seq_ctrl.sv - self-checking bench for dtw_seq_ctrl with a behavioural memory and pair model.
module tb_dtw_seq_ctrl;
  localparam int N = 32, AW = 8, S = 256;

  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;

  logic          wr_en, wr_sel, wr_clr, start, abort, pair_ready;
  logic [N-1:0]  wr_data;
  logic [AW-1:0] temp_addr, test_addr, pair_i, pair_j;
  logic          temp_we, test_we, pair_valid, first_col, last_col, last_pair;
  logic [N-1:0]  template_data, test_data, temp_out, test_out, pair_temp, pair_test;
  logic [AW:0]   temp_cnt, test_cnt;
  logic          busy, done, start_err;

  dtw_seq_ctrl #(.N(N), .AW(AW), .Sample(S)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .wr_clr(wr_clr), .start(start), .abort(abort),
    .temp_mem_addr(temp_addr), .test_mem_addr(test_addr),
    .temp_mem_write_enable(temp_we), .test_mem_write_enable(test_we),
    .template_data(template_data), .test_data(test_data),
    .temp_memory_out(temp_out), .test_memory_out(test_out),
    .pair_valid(pair_valid), .pair_ready(pair_ready),
    .pair_temp(pair_temp), .pair_test(pair_test),
    .pair_i(pair_i), .pair_j(pair_j),
    .first_col(first_col), .last_col(last_col), .last_pair(last_pair),
    .temp_cnt(temp_cnt), .test_cnt(test_cnt),
    .busy(busy), .done(done), .start_err(start_err)
  );

  // Synchronous-read memories with one cycle of latency.
  logic [N-1:0] tmem [0:S-1];
  logic [N-1:0] smem [0:S-1];
  always @(posedge clk) begin
    if (temp_we) tmem[temp_addr] <= template_data;
    if (test_we) smem[test_addr] <= test_data;
    temp_out <= tmem[temp_addr];
    test_out <= smem[test_addr];
  end

  logic [N-1:0] tref[$];
  logic [N-1:0] sref[$];
  int n_tests = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_in();
    wr_en = 0; wr_clr = 0; start = 0; abort = 0; pair_ready = 0;
  endtask

  typedef struct {
    bit en; bit sel; bit clr; bit st; logic [N-1:0] d;
    bit twe; bit swe; int ta; int sa; int tc; int sc; bit err;
  } vec_t;
  vec_t vt[9];

  task automatic load(input int nt, input int ns);
    @(negedge clk); idle_in(); wr_clr = 1;
    tref.delete(); sref.delete();
    for (int k = 0; k < nt; k++) begin
      @(negedge clk); idle_in(); wr_en = 1; wr_sel = 0; wr_data = $urandom;
      tref.push_back(wr_data);
    end
    for (int k = 0; k < ns; k++) begin
      @(negedge clk); idle_in(); wr_en = 1; wr_sel = 1; wr_data = $urandom;
      sref.push_back(wr_data);
    end
    @(negedge clk); idle_in(); #1;
    chk("load_temp_cnt", temp_cnt, nt);
    chk("load_test_cnt", test_cnt, ns);
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready
  task automatic traverse(input int mode, input int abort_at);
    int nt, total, acc, cyc, i, j;
    bit fin;
    nt = tref.size(); total = nt * sref.size();
    acc = 0; cyc = 0; fin = 0;
    @(negedge clk); idle_in(); start = 1; #1;
    chk("start_taddr", temp_addr, 0);
    chk("start_saddr", test_addr, 0);
    chk("start_we", {temp_we, test_we}, 0);
    @(negedge clk); idle_in(); #1;
    chk("prime_busy", busy, 1);
    chk("prime_valid", pair_valid, 0);
    while (!fin) begin
      @(negedge clk);
      case (mode)
        0:       pair_ready = 1;
        1:       pair_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: pair_ready = ($urandom % 3) != 0;
      endcase
      abort = (abort_at >= 0 && acc == abort_at);
      #1;
      if (pair_valid) begin
        i = acc / nt; j = acc % nt;
        chk("pair_i", pair_i, i);
        chk("pair_j", pair_j, j);
        chk("pair_temp", pair_temp, tref[j]);
        chk("pair_test", pair_test, sref[i]);
        chk("first_col", first_col, j == 0);
        chk("last_col", last_col, j == nt - 1);
        chk("last_pair", last_pair, acc == total - 1);
        if (abort) begin
          @(negedge clk); idle_in(); #1;
          chk("abort_busy", busy, 0);
          chk("abort_valid", pair_valid, 0);
          chk("abort_done", done, 0);
          fin = 1;
        end else if (pair_ready) begin
          acc++;
        end
      end else if (done) begin
        chk("pairs_total", acc, total);
        chk("done_busy", busy, 1);
        @(negedge clk); idle_in(); #1;
        chk("after_done_busy", busy, 0);
        chk("after_done_pulse", done, 0);
        fin = 1;
      end else begin
        chk("run_valid", pair_valid, 1);
        fin = 1;
      end
      cyc++;
      if (!fin && cyc > 2000 + 4 * total) begin
        n_tests++; n_fail++;
        $display("FAIL traverse_timeout: got %0d pairs, expected %0d", acc, total);
        fin = 1;
      end
    end
  endtask

  initial begin
    idle_in(); wr_data = '0; wr_sel = 0;
    wr_en = 1; #2;
    chk("rst_busy", busy, 0);
    chk("rst_valid", pair_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_err", start_err, 0);
    chk("rst_cnts", {temp_cnt, test_cnt}, 0);
    chk("rst_addrs", {temp_addr, test_addr}, 0);
    chk("rst_we", {temp_we, test_we}, 0);
    chk("rst_pair_ij", {pair_i, pair_j}, 0);
    @(negedge clk); idle_in(); rst = 1;

    vt[0] = '{1, 0, 0, 0, 32'h11, 1, 0, 0, 0, 0, 0, 0};
    vt[1] = '{1, 0, 0, 0, 32'h22, 1, 0, 1, 0, 1, 0, 0};
    vt[2] = '{1, 1, 0, 1, 32'h99, 0, 0, 2, 0, 2, 0, 0};
    vt[3] = '{1, 1, 0, 0, 32'h33, 0, 1, 2, 0, 2, 0, 1};
    vt[4] = '{1, 0, 1, 0, 32'h44, 0, 0, 2, 1, 2, 1, 0};
    vt[5] = '{1, 1, 0, 0, 32'h55, 0, 1, 0, 0, 0, 0, 0};
    vt[6] = '{0, 0, 0, 0, 32'h66, 0, 0, 0, 1, 0, 1, 0};
    vt[7] = '{0, 0, 1, 0, 32'h77, 0, 0, 0, 1, 0, 1, 0};
    vt[8] = '{0, 0, 0, 0, 32'h88, 0, 0, 0, 0, 0, 0, 0};
    for (int v = 0; v < 9; v++) begin
      @(negedge clk); idle_in();
      wr_en = vt[v].en; wr_sel = vt[v].sel; wr_clr = vt[v].clr;
      start = vt[v].st; wr_data = vt[v].d; #1;
      chk("vec_temp_we", temp_we, vt[v].twe);
      chk("vec_test_we", test_we, vt[v].swe);
      chk("vec_temp_addr", temp_addr, vt[v].ta);
      chk("vec_test_addr", test_addr, vt[v].sa);
      chk("vec_temp_cnt", temp_cnt, vt[v].tc);
      chk("vec_test_cnt", test_cnt, vt[v].sc);
      chk("vec_start_err", start_err, vt[v].err);
      chk("vec_busy", busy, 0);
    end

    // Template overfill and start with an empty test memory.
    @(negedge clk); idle_in(); wr_clr = 1;
    for (int k = 0; k < S; k++) begin
      @(negedge clk); idle_in(); wr_en = 1; wr_sel = 0; wr_data = k;
    end
    @(negedge clk); idle_in(); wr_en = 1; wr_sel = 0; wr_data = 32'hdead; #1;
    chk("full_we", temp_we, 0);
    chk("full_cnt", temp_cnt, S);
    @(negedge clk); idle_in(); #1;
    chk("full_cnt_hold", temp_cnt, S);
    start = 1;
    @(negedge clk); idle_in(); #1;
    chk("empty_start_err", start_err, 1);
    chk("empty_start_busy", busy, 0);
    @(negedge clk); #1;
    chk("start_err_pulse", start_err, 0);

    // Clear beats a simultaneous write.
    @(negedge clk); idle_in(); wr_clr = 1; wr_en = 1; wr_sel = 0; #1;
    chk("clr_we", temp_we, 0);
    @(negedge clk); idle_in(); #1;
    chk("clr_cnts", {temp_cnt, test_cnt}, 0);
    start = 1;
    @(negedge clk); idle_in(); #1;
    chk("clr_start_err", start_err, 1);
    chk("clr_start_busy", busy, 0);

    load(3, 2);
    traverse(0, -1);
    traverse(1, -1);
    traverse(0, 2);
    traverse(0, -1);
    for (int r = 0; r < 4; r++) begin
      load($urandom_range(1, 6), $urandom_range(1, 5));
      traverse(2, -1);
    end
    load(S, 2);
    traverse(2, -1);

    // Asynchronous reset in the middle of a traversal.
    load(3, 2);
    @(negedge clk); idle_in(); start = 1;
    @(negedge clk); idle_in();
    @(negedge clk); idle_in(); #1;
    chk("pre_rst_valid", pair_valid, 1);
    wr_en = 1; wr_sel = 0; #1;
    rst = 0; #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", pair_valid, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_addrs", {temp_addr, test_addr}, 0);
    chk("mid_rst_we", {temp_we, test_we}, 0);
    chk("mid_rst_pair_ij", {pair_i, pair_j}, 0);
    @(negedge clk); rst = 1; wr_en = 1; wr_sel = 0; wr_data = 32'h5a; #1;
    chk("post_rst_cnts", {temp_cnt, test_cnt}, 0);
    chk("post_rst_we", temp_we, 1);
    chk("post_rst_addr", temp_addr, 0);
    @(negedge clk); idle_in(); #1;
    chk("post_rst_write", temp_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
